bcd_div_scheduler: RTL and testbench

- Converts a measured binary frequency word into NDIGITS decimal digits for the 7-segment scanner.
- Reuses one shared divide-by-10 divider (div_fsm handshake) instead of a cascade of NDIGITS dividers.
- Sits between the frequency counter output and the 7-segment display driver.
- Sequences the divider once per digit, then publishes a coherent digit set with leading-zero blank flags and an overflow flag.

---
 rtl/bcd_div_scheduler.sv | 143 ++++++++++++++
 tb/tb_bcd_div_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_div_scheduler.sv
`timescale 1ns / 1ps
// bcd_div_scheduler: converts a binary word into NDIGITS BCD digits by driving one
// shared divide-by-10 unit once per digit, then publishes the digit set atomically.
//
// Ports:
//   sys_clk, sys_rst_n   clock, asynchronous active-low reset
//   start, data_in       conversion request (accepted in IDLE only) and binary value
//   busy, done           busy from the cycle after an accepted start through FINISH;
//                        done pulses once when results update
//   digits, blank        BCD result (digit 0 least significant) and leading-zero blanks
//   overflow             value needed more than NDIGITS digits
//   div_en, div_dividend, div_divisor             request side of the shared divider
//   div_ready, div_quotient, div_remainder, div_vld  response side of the shared divider
module bcd_div_scheduler #(
  parameter int unsigned DATAWIDTH = 30,
  parameter int unsigned NDIGITS   = 8
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   start,
  input  logic [DATAWIDTH-1:0]   data_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NDIGITS-1:0]   digits,
  output logic [NDIGITS-1:0]     blank,
  output logic                   overflow,
  output logic                   div_en,
  output logic [DATAWIDTH-1:0]   div_dividend,
  output logic [DATAWIDTH-1:0]   div_divisor,
  input  logic                   div_ready,
  input  logic [DATAWIDTH-1:0]   div_quotient,
  input  logic [DATAWIDTH-1:0]   div_remainder,
  input  logic                   div_vld
);

  localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);
  // Reset display shows a single "0": every digit blanked except the least significant.
  localparam logic [NDIGITS-1:0] BlankRst = {{(NDIGITS - 1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StFinish} state_e;

  state_e                 state_q, state_d;
  logic [DATAWIDTH-1:0]   work_q, work_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NDIGITS-1:0]   digits_q, digits_d;
  logic [NDIGITS-1:0]     blank_q, blank_d;
  logic                   overflow_q, overflow_d;

  logic [4*NDIGITS-1:0]   merged;
  logic [NDIGITS-1:0]     blank_calc;
  logic                   zero_run;
  logic                   unused_rem;

  // Only the low nibble of the remainder can be a decimal digit.
  assign unused_rem = ^div_remainder[DATAWIDTH-1:4];

  // Shadow digits with the digit arriving this cycle merged in, plus its blank mask.
  always_comb begin
    merged = shadow_q;
    merged[{idx_q, 2'b00} +: 4] = div_remainder[3:0];
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int i = NDIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run & (merged[4*i +: 4] == 4'd0);
      blank_calc[i] = zero_run;
    end
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    digits_d   = digits_q;
    blank_d    = blank_q;
    overflow_d = overflow_q;
    div_en     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d   = data_in;
          idx_d    = '0;
          shadow_d = '0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (div_ready) begin
          div_en  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (div_vld) begin
          shadow_d = merged;
          work_d   = div_quotient;
          if (div_quotient == '0 || idx_q == LastIdx) begin
            digits_d   = merged;
            blank_d    = blank_calc;
            overflow_d = (div_quotient != '0);
            state_d    = StFinish;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StIssue;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      idx_q      <= '0;
      shadow_q   <= '0;
      digits_q   <= '0;
      blank_q    <= BlankRst;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      digits_q   <= digits_d;
      blank_q    <= blank_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFinish);
  assign digits       = digits_q;
  assign blank        = blank_q;
  assign overflow     = overflow_q;
  assign div_dividend = work_q;
  assign div_divisor  = DATAWIDTH'(10);

endmodule

// File: tb/tb_bcd_div_scheduler.sv
`timescale 1ns / 1ps
module tb_bcd_div_scheduler;

  localparam int unsigned DW = 30;
  localparam int unsigned ND = 8;
  localparam int unsigned LD = 32;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DW-1:0]     data_in = '0;
  logic              busy, done, overflow, div_en;
  logic [4*ND-1:0]   digits;
  logic [ND-1:0]     blank;
  logic [DW-1:0]     div_dividend, div_divisor;
  logic              div_ready = 1'b1;
  logic [DW-1:0]     div_quotient = '0;
  logic [DW-1:0]     div_remainder = '0;
  logic              div_vld = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  bcd_div_scheduler #(.DATAWIDTH(DW), .NDIGITS(ND)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .start        (start),
    .data_in      (data_in),
    .busy         (busy),
    .done         (done),
    .digits       (digits),
    .blank        (blank),
    .overflow     (overflow),
    .div_en       (div_en),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_ready    (div_ready),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_vld      (div_vld)
  );

  always #5 sys_clk = ~sys_clk;

  // Behavioral divider: result pulse sampled LD edges after div_en. Not reset, so an
  // operation aborted by reset still produces a late div_vld.
  logic          m_pend = 1'b0;
  int            m_cnt = 0;
  logic [DW-1:0] m_q = '0, m_r = '0;
  int            en_count = 0;
  logic [DW-1:0] div_log[$];

  always @(posedge sys_clk) begin
    div_vld <= 1'b0;
    if (div_en) begin
      m_pend   <= 1'b1;
      m_cnt    <= LD - 1;
      m_q      <= div_dividend / DW'(10);
      m_r      <= div_dividend % DW'(10);
      en_count <= en_count + 1;
      div_log.push_back(div_dividend);
    end else if (m_pend) begin
      if (m_cnt == 1) begin
        div_vld       <= 1'b1;
        div_quotient  <= m_q;
        div_remainder <= m_r;
        m_pend        <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Start is high during cycle 1; returns at the negedge of cycle 2.
  task automatic do_start(input logic [DW-1:0] v);
    @(negedge sys_clk);
    start   = 1'b1;
    data_in = v;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 2;
    ok  = 1'b0;
    while (cyc < 3000) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge sys_clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    n_checks++; if (div_en !== 1'b0) begin n_fail++; $display("FAIL rst_div_en got %b want 0", div_en); end
    n_checks++; if (div_dividend !== '0) begin n_fail++; $display("FAIL rst_dividend got %h want 0", div_dividend); end
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL rst_digits got %h want 0", digits); end
    n_checks++; if (blank !== 8'hFE) begin n_fail++; $display("FAIL rst_blank got %h want fe", blank); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", overflow); end
    n_checks++; if (div_divisor !== DW'(10)) begin n_fail++; $display("FAIL divisor got %0d want 10", div_divisor); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_full_digits();
    int cyc; bit ok; int b;
    b = en_count;
    do_start(DW'(12345678));
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL full_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h12345678) begin n_fail++; $display("FAIL full_digits got %h want 12345678", digits); end
    n_checks++; if (blank !== 8'h00) begin n_fail++; $display("FAIL full_blank got %h want 00", blank); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow got %b want 0", overflow); end
    n_checks++; if (en_count - b != 8) begin n_fail++; $display("FAIL full_div_count got %0d want 8", en_count - b); end
    n_checks++; if (cyc != 266) begin n_fail++; $display("FAIL full_latency got %0d want 266", cyc); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy_finish got %b want 1", busy); end
    @(negedge sys_clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_pulse got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after got %b want 0", busy); end
  endtask

  task automatic test_zero();
    int cyc; bit ok; int b; int lb;
    b  = en_count;
    lb = div_log.size();
    do_start(DW'(0));
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL zero_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL zero_digits got %h want 0", digits); end
    n_checks++; if (blank !== 8'hFE) begin n_fail++; $display("FAIL zero_blank got %h want fe", blank); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL zero_overflow got %b want 0", overflow); end
    n_checks++; if (en_count - b != 1) begin n_fail++; $display("FAIL zero_div_count got %0d want 1", en_count - b); end
    n_checks++; if (cyc != 35) begin n_fail++; $display("FAIL zero_latency got %0d want 35", cyc); end
    n_checks++;
    if (div_log.size() <= lb || div_log[lb] !== '0) begin
      n_fail++; $display("FAIL zero_dividend got size %0d want dividend 0", div_log.size() - lb);
    end
  endtask

  task automatic test_early_stop();
    int cyc; bit ok; int b; int lb;
    logic [DW-1:0] exp_div[3];
    exp_div[0] = DW'(305); exp_div[1] = DW'(30); exp_div[2] = DW'(3);
    b  = en_count;
    lb = div_log.size();
    do_start(DW'(305));
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL e305_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h00000305) begin n_fail++; $display("FAIL e305_digits got %h want 00000305", digits); end
    n_checks++; if (blank !== 8'hF8) begin n_fail++; $display("FAIL e305_blank got %h want f8", blank); end
    n_checks++; if (en_count - b != 3) begin n_fail++; $display("FAIL e305_div_count got %0d want 3", en_count - b); end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (div_log.size() <= lb + i || div_log[lb+i] !== exp_div[i]) begin
        n_fail++; $display("FAIL e305_dividend%0d got %0d want %0d", i,
                           (div_log.size() > lb + i) ? div_log[lb+i] : '1, exp_div[i]);
      end
    end
  endtask

  task automatic test_overflow();
    int cyc; bit ok; int b;
    b = en_count;
    do_start(DW'(999999999));
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h99999999) begin n_fail++; $display("FAIL ovf_digits got %h want 99999999", digits); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
    n_checks++; if (blank !== 8'h00) begin n_fail++; $display("FAIL ovf_blank got %h want 00", blank); end
    n_checks++; if (en_count - b != 8) begin n_fail++; $display("FAIL ovf_div_count got %0d want 8", en_count - b); end
  endtask

  task automatic test_busy_stall();
    int cyc; bit ok; int b; bit bad;
    b   = en_count;
    bad = 1'b0;
    div_ready = 1'b0;
    do_start(DW'(4021));
    repeat (10) begin
      if (div_en !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      @(negedge sys_clk);
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL stall_hold got div_en/busy wrong want div_en=0 busy=1"); end
    n_checks++; if (en_count != b) begin n_fail++; $display("FAIL stall_no_issue got %0d want 0", en_count - b); end
    // Start while busy must be ignored.
    start     = 1'b1;
    data_in   = DW'(77);
    div_ready = 1'b1;
    @(negedge sys_clk);
    n_checks++; if (en_count - b != 1) begin n_fail++; $display("FAIL stall_issue_once got %0d want 1", en_count - b); end
    repeat (2) @(negedge sys_clk);
    start = 1'b0;
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL busy_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h00004021) begin n_fail++; $display("FAIL busy_digits got %h want 00004021", digits); end
    n_checks++; if (blank !== 8'hF0) begin n_fail++; $display("FAIL busy_blank got %h want f0", blank); end
    n_checks++; if (en_count - b != 4) begin n_fail++; $display("FAIL busy_div_count got %0d want 4", en_count - b); end
    @(negedge sys_clk);
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok; int b; int w; bit bad;
    b = en_count;
    w = 0;
    do_start(DW'(12345678));
    while (en_count - b < 4 && w < 500) begin
      @(negedge sys_clk);
      w++;
    end
    n_checks++; if (en_count - b != 4) begin n_fail++; $display("FAIL mid_reach got %0d want 4", en_count - b); end
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL mid_digits got %h want 0", digits); end
    n_checks++; if (blank !== 8'hFE) begin n_fail++; $display("FAIL mid_blank got %h want fe", blank); end
    n_checks++; if (div_dividend !== '0) begin n_fail++; $display("FAIL mid_dividend got %h want 0", div_dividend); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    bad = 1'b0;
    // The divider's late result arrives inside this window and must be ignored.
    repeat (40) begin
      @(negedge sys_clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL late_vld_state got busy/done active want idle"); end
    n_checks++; if (digits !== 32'h0) begin n_fail++; $display("FAIL late_vld_digits got %h want 0", digits); end
    n_checks++; if (en_count - b != 4) begin n_fail++; $display("FAIL late_vld_issue got %0d want 4", en_count - b); end
    b = en_count;
    do_start(DW'(42));
    wait_done(cyc, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL post_timeout got no done want done"); end
    n_checks++; if (digits !== 32'h00000042) begin n_fail++; $display("FAIL post_digits got %h want 00000042", digits); end
    n_checks++; if (blank !== 8'hFC) begin n_fail++; $display("FAIL post_blank got %h want fc", blank); end
    n_checks++; if (en_count - b != 2) begin n_fail++; $display("FAIL post_div_count got %0d want 2", en_count - b); end
  endtask

  initial begin
    test_reset();
    test_full_digits();
    test_zero();
    test_early_stop();
    test_overflow();
    test_busy_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
